// File: rtl/mod_74x161_chain_pkg.sv
// Shared definitions for the 74x161 counter bank.
// Optional feature switch: MOD_74X161_DIR_EN
//   undefined (default) : up-only counting, RCO decodes all ones per stage
//   defined             : UP port added; UP=0 counts down and RCO decodes all zeros
package mod_74x161_chain_pkg;

    // Width of one counter stage.
    localparam int CHIP_W    = 4;
    // Largest supported number of cascaded stages.
    localparam int MAX_CHIPS = 8;

    localparam logic [0:CHIP_W-1] NIB_ONES = '1;
    localparam logic [0:CHIP_W-1] NIB_ZERO = '0;

    // Terminal-count decode of one stage: all ones when counting up,
    // all zeros when counting down.
    function automatic logic nib_terminal(input logic [0:CHIP_W-1] q,
                                          input logic              up);
        return up ? (q == NIB_ONES) : (q == NIB_ZERO);
    endfunction

endpackage

// File: rtl/mod_74x161_4.sv
// One 4-bit synchronous counter stage (74x161 style).
// Async active-high clear, sync active-low load, ENP/ENT count enables.
// Optional feature switch: MOD_74X161_DIR_EN (adds UP direction input).
// Bit 0 of D/Q is the MSB.
module mod_74x161_4
    import mod_74x161_chain_pkg::*;
(
    input  logic              CLK,
    input  logic              CLR,
    input  logic              LOAD_N,
    input  logic              ENP,
    input  logic              ENT,
    input  logic [0:CHIP_W-1] D,
    output logic [0:CHIP_W-1] Q,
    output logic              RCO
`ifdef MOD_74X161_DIR_EN
    ,
    input  logic              UP
`endif
);

    logic              dir_up;
    logic              count_en;
    logic [0:CHIP_W-1] q_r;
    logic [0:CHIP_W-1] q_step;

`ifdef MOD_74X161_DIR_EN
    assign dir_up = UP;
`else
    assign dir_up = 1'b1;
`endif

    // A stage advances only when both enables are high; ENT carries the
    // ripple from the lower stages so a cascade behaves as one wide counter.
    assign count_en = ENP & ENT;

    // Next count value in the selected direction, wrapping within the nibble.
    always_comb begin
        q_step = q_r;
        if (dir_up)
            q_step = q_r + 4'd1;
        else
            q_step = q_r - 4'd1;
    end

    // State register: clear beats load, load beats count, otherwise hold.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)
            q_r <= NIB_ZERO;
        else if (!LOAD_N)
            q_r <= D;
        else if (count_en)
            q_r <= q_step;
    end

    assign Q = q_r;

    // Ripple carry is purely combinational from ENT and Q; ENP and LOAD_N
    // deliberately do not gate it.
    assign RCO = ENT & nib_terminal(q_r, dir_up);

endmodule

// File: rtl/mod_74x161_chain.sv
// Cascade of CHIPS 74x161-style stages forming one 4*CHIPS-bit counter.
// Each stage's RCO drives the next stage's ENT; top RCO is the last stage's.
// Optional feature switch: MOD_74X161_DIR_EN (adds UP direction input).
// Bit 0 of D/Q is the MSB; stage 0 is the least-significant nibble.
module mod_74x161_chain
    import mod_74x161_chain_pkg::*;
#(
    parameter int CHIPS = 2
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      LOAD_N,
    input  logic                      ENP,
    input  logic                      ENT,
    input  logic [0:CHIP_W*CHIPS-1]   D,
    output logic [0:CHIP_W*CHIPS-1]   Q,
    output logic                      RCO
`ifdef MOD_74X161_DIR_EN
    ,
    input  logic                      UP
`endif
);

    localparam int N = CHIP_W * CHIPS;

    // ent_chain[k] is ENT of stage k; ent_chain[k+1] is RCO of stage k.
    logic [0:CHIPS] ent_chain;

    assign ent_chain[0] = ENT;

    for (genvar k = 0; k < CHIPS; k++) begin : g_stage
        // Stage k occupies Q[N-4k-4 : N-4k-1] (MSB-first numbering).
        localparam int BASE = N - CHIP_W*k - CHIP_W;

        mod_74x161_4 u_stage (
            .CLK    (CLK),
            .CLR    (CLR),
            .LOAD_N (LOAD_N),
            .ENP    (ENP),
            .ENT    (ent_chain[k]),
            .D      (D[BASE +: CHIP_W]),
            .Q      (Q[BASE +: CHIP_W]),
            .RCO    (ent_chain[k+1])
`ifdef MOD_74X161_DIR_EN
            ,
            .UP     (UP)
`endif
        );
    end

    assign RCO = ent_chain[CHIPS];

endmodule

// File: tb/tb_mod_74x161_chain.sv
// Self-checking bench for mod_74x161_chain (CHIPS = 2, N = 8).
// Optional feature switch: MOD_74X161_DIR_EN (enables direction tests).
module tb_mod_74x161_chain;

    localparam int CHIPS = 2;
    localparam int N     = 4 * CHIPS;
    localparam int MODV  = 1 << N;
    localparam int MAXV  = MODV - 1;

    logic         CLK = 1'b0;
    logic         CLR = 1'b1;
    logic         LOAD_N = 1'b1;
    logic         ENP = 1'b0;
    logic         ENT = 1'b0;
    logic [0:N-1] D = '0;
    logic [0:N-1] Q;
    logic         RCO;
    logic         up_tb = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int mq       = 0;   // reference counter value as a plain integer

    mod_74x161_chain #(.CHIPS(CHIPS)) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .LOAD_N (LOAD_N),
        .ENP    (ENP),
        .ENT    (ENT),
        .D      (D),
        .Q      (Q),
        .RCO    (RCO)
`ifdef MOD_74X161_DIR_EN
        ,
        .UP     (up_tb)
`endif
    );

    always #5 CLK = ~CLK;

    // Expected RCO: ENT and counter at its terminal value for the direction.
    function automatic logic exp_rco();
        if (up_tb) return ENT && (mq == MAXV);
        return ENT && (mq == 0);
    endfunction

    // Advance one rising edge, apply the counter rules to the model, settle.
    task automatic tick();
        @(posedge CLK);
        if (CLR)
            mq = 0;
        else if (!LOAD_N)
            mq = int'(D);
        else if (ENP && ENT)
            mq = up_tb ? (mq + 1) % MODV : (mq + MODV - 1) % MODV;
        #1;
    endtask

    task automatic load(input int v);
        LOAD_N = 1'b0; D = N'(v);
        tick();
        LOAD_N = 1'b1;
    endtask

    task automatic test_reset();
        ENT = 1'b1; ENP = 1'b1;
        #2;
        n_checks++;
        if (Q !== '0) begin n_fail++; $display("FAIL reset_q: got %h want 00", Q); end
        n_checks++;
        if (RCO !== 1'b0) begin n_fail++; $display("FAIL reset_rco: got %b want 0", RCO); end
        LOAD_N = 1'b0; D = 8'hFF;
        repeat (2) tick();
        n_checks++;
        if (Q !== '0) begin n_fail++; $display("FAIL reset_edges_q: got %h want 00", Q); end
        LOAD_N = 1'b1;
        #2 CLR = 1'b0;
        mq = 0;
    endtask

    task automatic test_clear_async();
        load(8'hA5);
        n_checks++;
        if (Q !== 8'hA5) begin n_fail++; $display("FAIL clr_pre_q: got %h want a5", Q); end
        ENP = 1'b1; ENT = 1'b1;
        #2 CLR = 1'b1;
        #1;
        mq = 0;
        n_checks++;
        if (Q !== '0) begin n_fail++; $display("FAIL clr_async_q: got %h want 00", Q); end
        n_checks++;
        if (RCO !== 1'b0) begin n_fail++; $display("FAIL clr_async_rco: got %b want 0", RCO); end
        LOAD_N = 1'b0; D = 8'h77;
        tick();
        n_checks++;
        if (Q !== '0) begin n_fail++; $display("FAIL clr_hold_q: got %h want 00", Q); end
        LOAD_N = 1'b1;
        #2 CLR = 1'b0;
        tick();
        n_checks++;
        if (Q !== 8'h01) begin n_fail++; $display("FAIL clr_release_q: got %h want 01", Q); end
        ENP = 1'b0;
    endtask

    task automatic test_load_priority();
        ENP = 1'b1; ENT = 1'b1;
        load(8'h3C);
        n_checks++;
        if (Q !== 8'h3C) begin n_fail++; $display("FAIL load_prio_q: got %h want 3c", Q); end
        ENP = 1'b0;
    endtask

    task automatic test_nibble_carry();
        ENT = 1'b1; ENP = 1'b0;
        load(8'h0F);
        n_checks++;
        if (dut.ent_chain[1] !== 1'b1) begin n_fail++; $display("FAIL nib_low_rco: got %b want 1", dut.ent_chain[1]); end
        n_checks++;
        if (RCO !== 1'b0) begin n_fail++; $display("FAIL nib_top_rco: got %b want 0", RCO); end
        ENP = 1'b1;
        tick();
        n_checks++;
        if (Q !== 8'h10) begin n_fail++; $display("FAIL nib_carry_q: got %h want 10", Q); end
        ENP = 1'b0;
    endtask

    task automatic test_wrap();
        logic [0:N-1] want_q   [3];
        logic         want_rco [3];
        want_q   = '{8'hFF, 8'h00, 8'h01};
        want_rco = '{1'b1, 1'b0, 1'b0};
        ENT = 1'b1; ENP = 1'b0;
        load(8'hFE);
        n_checks++;
        if (RCO !== 1'b0) begin n_fail++; $display("FAIL wrap_fe_rco: got %b want 0", RCO); end
        ENP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (Q !== want_q[i]) begin n_fail++; $display("FAIL wrap_q[%0d]: got %h want %h", i, Q, want_q[i]); end
            n_checks++;
            if (RCO !== want_rco[i]) begin n_fail++; $display("FAIL wrap_rco[%0d]: got %b want %b", i, RCO, want_rco[i]); end
        end
        ENP = 1'b0;
    endtask

    task automatic test_enables();
        ENT = 1'b1; ENP = 1'b0;
        load(8'h40);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (Q !== 8'h40) begin n_fail++; $display("FAIL enp_hold_q[%0d]: got %h want 40", i, Q); end
        end
        load(8'hFF);
        n_checks++;
        if (RCO !== 1'b1) begin n_fail++; $display("FAIL enp0_rco: got %b want 1", RCO); end
        ENT = 1'b0; ENP = 1'b1;
        #1;
        n_checks++;
        if (RCO !== 1'b0) begin n_fail++; $display("FAIL ent0_rco: got %b want 0", RCO); end
        tick();
        n_checks++;
        if (Q !== 8'hFF) begin n_fail++; $display("FAIL ent0_hold_q: got %h want ff", Q); end
        ENP = 1'b0;
    endtask

`ifdef MOD_74X161_DIR_EN
    task automatic test_direction();
        ENT = 1'b1; ENP = 1'b0; up_tb = 1'b0;
        load(8'h01);
        ENP = 1'b1;
        tick();
        n_checks++;
        if (Q !== 8'h00) begin n_fail++; $display("FAIL down_q0: got %h want 00", Q); end
        n_checks++;
        if (RCO !== 1'b1) begin n_fail++; $display("FAIL down_rco0: got %b want 1", RCO); end
        tick();
        n_checks++;
        if (Q !== 8'hFF) begin n_fail++; $display("FAIL down_q1: got %h want ff", Q); end
        n_checks++;
        if (RCO !== 1'b0) begin n_fail++; $display("FAIL down_rco1: got %b want 0", RCO); end
        ENP = 1'b0; up_tb = 1'b1;
    endtask
`endif

    // Random mix of loads, counts, holds and mid-cycle clears vs the model.
    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            LOAD_N = ($urandom_range(0, 7) != 0);
            ENP    = ($urandom_range(0, 3) != 0);
            ENT    = ($urandom_range(0, 3) != 0);
            D      = N'($urandom);
`ifdef MOD_74X161_DIR_EN
            up_tb  = $urandom_range(0, 1) == 1;
`endif
            if ($urandom_range(0, 19) == 0) begin
                #2 CLR = 1'b1;
                #1 mq = 0;
                n_checks++;
                if (Q !== '0) begin n_fail++; $display("FAIL rnd_clr_q[%0d]: got %h want 00", i, Q); end
                #1 CLR = 1'b0;
            end
            #1;
            n_checks++;
            if (RCO !== exp_rco()) begin n_fail++; $display("FAIL rnd_rco_pre[%0d]: got %b want %b", i, RCO, exp_rco()); end
            tick();
            n_checks++;
            if (Q !== N'(mq)) begin n_fail++; $display("FAIL rnd_q[%0d]: got %h want %h", i, Q, N'(mq)); end
            n_checks++;
            if (RCO !== exp_rco()) begin n_fail++; $display("FAIL rnd_rco[%0d]: got %b want %b", i, RCO, exp_rco()); end
        end
        LOAD_N = 1'b1; ENP = 1'b0; up_tb = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clear_async();
        test_load_priority();
        test_nibble_carry();
        test_wrap();
        test_enables();
`ifdef MOD_74X161_DIR_EN
        test_direction();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
